hci_tcdm_bank_ctrl: RTL and testbench
=====================================

# hci_tcdm_bank_ctrl

Per-bank controller between one memory-side port of the HCI logarithmic interconnect and a single-port SRAM macro. It accepts word-addressed requests carrying a requester ID and an atomic test-and-set flag. It drives the SRAM, returns read data, a response valid and the echoed ID with fixed one-cycle latency, and executes test-and-set as a read of the old value followed by an internal all-ones write. One instance per bank; N_MEM instances per cluster.

## Interface
- AW, 10: bank word-address width (SRAM depth 2^AW words)
- DW, 32: data width
- BW, 8: byte width; byte-enable width DW/BW
- UW, 0: user width, stored alongside data; 0 disables the user field
- IW, 20: requester ID width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  1  request valid
- ts_set_i  in  1  request is a test-and-set, only meaningful with req_i=1 and wen_i=1
- add_i  in  AW  word address
- wen_i  in  1  1=read, 0=write
- data_i  in  UW+DW  write data, {user,data}
- be_i  in  DW/BW  byte enables; the user field is written when any bit is set
- id_i  in  IW  requester ID
- gnt_o  out  1  request accepted this cycle
- r_valid_o  out  1  response valid
- r_data_o  out  UW+DW  read data
- r_id_o  out  IW  ID of the request being answered
- sram_req_o  out  1  SRAM chip enable
- sram_we_o  out  1  SRAM write enable (active-high)
- sram_add_o  out  AW  SRAM address
- sram_wdata_o  out  UW+DW  SRAM write data
- sram_be_o  out  UW+DW  SRAM bit-enable, expanded from be_i
- sram_rdata_i  in  UW+DW  SRAM read data, valid one cycle after the read

## Operation
- States: IDLE (accepting requests) and TS_WR (completing a test-and-set).
- In IDLE, gnt_o = 1. req_i is forwarded combinationally to the SRAM: sram_req_o=req_i, sram_we_o=~wen_i, sram_add_o=add_i, sram_wdata_o=data_i, sram_be_o = each be_i bit replicated BW times, plus UW bits set when |be_i.
- A granted test-and-set (req_i & wen_i & ts_set_i) issues an SRAM read and latches add_i. The FSM moves IDLE->TS_WR.
- In TS_WR, gnt_o = 0. The SRAM write uses the latched address, data all-ones and full bit-enable. The FSM moves TS_WR->IDLE unconditionally.
- ts_set_i with wen_i=0 is an ordinary write.
- Every granted request (read, write, TS) produces r_valid_o=1 in the next cycle, with r_id_o = the registered id_i.
- Writes return r_data_o = previous read data; it is held and must not be consumed.
- Reads and TS return r_data_o = sram_rdata_i, passed through combinationally in the response cycle.
- The TS_WR write produces no response.
- Registered r_data is held between responses: the last read value is kept until the next read.

## Timing
- Reset values: state=IDLE, r_valid_o=0, r_id_o=0, held rdata=0, latched TS address=0. After reset, gnt_o=1 and all sram_* outputs are driven from idle inputs.
- Latency: request at cycle t -> response at t+1. Back-to-back requests give one response per cycle.
- Test-and-set:
  - t: gnt=1, read issued.
  - t+1: response carries the old value; the SRAM writes all-ones; gnt=0.
  - t+2: next request can be accepted.
- A request held during TS_WR is not granted. The requester must keep req_i and its payload stable until gnt_o=1.
- Reset asserted mid-TS (in TS_WR) aborts the all-ones write. There is no partial state; the word is left unmodified.
- Same-address read at t+2 after a TS returns all-ones.
- A read at t+1 after a write to the same address returns the new data. The SRAM is write-first across cycles.

## Structure
- hci_package gets hci_bank_state_t (IDLE, TS_WR) and the constant HCI_TS_PATTERN (all-ones).
- Byte-to-bit enable expansion goes in a small sub-module, hci_be_expand (parameters DW, BW, UW; purely combinational). It is reused by other memory-side blocks.
- The SRAM macro or behavioural model is external and not part of this block.

## Test plan
- Reset: rst_ni=0 then release -> r_valid_o=0, r_id_o=0, gnt_o=1.
- Write 0xDEADBEEF to add=5, id=3, then read add=5, id=7 -> r_valid at the cycle after each request; the read responds with r_data=0xDEADBEEF, r_id=7.
- Partial write be=4'b0010 of 0x0000AB00 to a word holding 0x11223344 -> a subsequent read returns 0x1122AB44.
- TS on add=9 (holding 0) with id=2, followed by a read of add=9 held on req_i:
  - gnt low exactly one cycle;
  - TS response r_data=0, r_id=2;
  - the read is granted at t+2 and returns 0xFFFFFFFF.
- 100 random back-to-back reads and writes checked against a scoreboard -> one response per grant; r_id matches in order; data matches the model.
- Reset pulse while in TS_WR -> after release, state=IDLE and the target word is unchanged.

Source files
------------

// File: rtl/hci_package.sv
`default_nettype none
// ============================================================================
// Module      : hci_package
// Description : Shared types and constants for the HCI memory-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package hci_package;

  // Bank controller states: accepting requests, or finishing a test-and-set.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } hci_bank_state_t;

  // Upper bound on {user,data} width that the test-and-set pattern can cover.
  localparam int unsigned HCI_TS_MAX_W = 1024;

  // Value written back by a test-and-set; users slice the low bits they need.
  localparam logic [HCI_TS_MAX_W-1:0] HCI_TS_PATTERN = '1;

endpackage
`default_nettype wire

// File: rtl/hci_be_expand.sv
`default_nettype none
// ============================================================================
// Module      : hci_be_expand
// Description : Expands byte enables into per-bit enables for {user,data}.
//               The user field is enabled whenever any byte is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module hci_be_expand #(
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned UW = 0
) (
  input  logic [DW/BW-1:0]  be_i,
  output logic [UW+DW-1:0]  bit_en_o
);

  // Each byte enable drives BW consecutive bit enables.
  for (genvar b = 0; b < DW/BW; b++) begin : g_byte
    assign bit_en_o[b*BW +: BW] = {BW{be_i[b]}};
  end

  // The user field travels with the word, so any byte write also updates it.
  if (UW > 0) begin : g_user
    assign bit_en_o[UW+DW-1:DW] = {UW{|be_i}};
  end

endmodule
`default_nettype wire

// File: rtl/hci_tcdm_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hci_tcdm_bank_ctrl
// Description : Per-bank controller between an HCI memory-side port and a
//               single-port SRAM. One-cycle response latency; test-and-set is
//               a read of the old value followed by an internal all-ones write.
// Revision    : 1.0 - initial release
// ============================================================================
module hci_tcdm_bank_ctrl
  import hci_package::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned UW = 0,
  parameter int unsigned IW = 20
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               ts_set_i,
  input  logic [AW-1:0]      add_i,
  input  logic               wen_i,
  input  logic [UW+DW-1:0]   data_i,
  input  logic [DW/BW-1:0]   be_i,
  input  logic [IW-1:0]      id_i,
  output logic               gnt_o,
  output logic               r_valid_o,
  output logic [UW+DW-1:0]   r_data_o,
  output logic [IW-1:0]      r_id_o,
  output logic               sram_req_o,
  output logic               sram_we_o,
  output logic [AW-1:0]      sram_add_o,
  output logic [UW+DW-1:0]   sram_wdata_o,
  output logic [UW+DW-1:0]   sram_be_o,
  input  logic [UW+DW-1:0]   sram_rdata_i
);

  localparam int unsigned LW = UW + DW;

  hci_bank_state_t state_q, state_d;
  logic [AW-1:0]   ts_add_q, ts_add_d;
  logic            r_valid_q, r_valid_d;
  logic            r_rd_q, r_rd_d;     // pending response comes from an SRAM read
  logic [IW-1:0]   r_id_q, r_id_d;
  logic [LW-1:0]   rdata_q, rdata_d;   // last read value, shown on write responses
  logic [LW-1:0]   be_bits;

  hci_be_expand #(
    .DW (DW),
    .BW (BW),
    .UW (UW)
  ) i_be_expand (
    .be_i     (be_i),
    .bit_en_o (be_bits)
  );

  // Next-state, SRAM drive and response bookkeeping.
  always_comb begin
    state_d      = state_q;
    ts_add_d     = ts_add_q;
    r_valid_d    = 1'b0;
    r_rd_d       = 1'b0;
    r_id_d       = r_id_q;
    rdata_d      = rdata_q;
    gnt_o        = 1'b0;
    sram_req_o   = req_i;
    sram_we_o    = ~wen_i;
    sram_add_o   = add_i;
    sram_wdata_o = data_i;
    sram_be_o    = be_bits;

    // Capture read data during its response cycle so later writes can show it.
    if (r_valid_q && r_rd_q) begin
      rdata_d = sram_rdata_i;
    end

    case (state_q)
      IDLE: begin
        gnt_o = 1'b1;
        if (req_i) begin
          r_valid_d = 1'b1;
          r_rd_d    = wen_i;
          r_id_d    = id_i;
          if (wen_i && ts_set_i) begin
            ts_add_d = add_i;
            state_d  = TS_WR;
          end
        end
      end
      TS_WR: begin
        // Port is busy with the internal write; the requester must wait.
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_add_o   = ts_add_q;
        sram_wdata_o = HCI_TS_PATTERN[LW-1:0];
        sram_be_o    = '1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ts_add_q  <= '0;
      r_valid_q <= 1'b0;
      r_rd_q    <= 1'b0;
      r_id_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ts_add_q  <= ts_add_d;
      r_valid_q <= r_valid_d;
      r_rd_q    <= r_rd_d;
      r_id_q    <= r_id_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read data passes straight through in its response cycle; otherwise hold.
  assign r_data_o  = r_rd_q ? sram_rdata_i : rdata_q;
  assign r_valid_o = r_valid_q;
  assign r_id_o    = r_id_q;

endmodule
`default_nettype wire

// File: tb/tb_hci_tcdm_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hci_tcdm_bank_ctrl
// Description : Scoreboard bench for hci_tcdm_bank_ctrl with a behavioural
//               SRAM. The driver queues expected responses at grant time; an
//               independent monitor pops and compares on every r_valid_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hci_tcdm_bank_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 20;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic          ts_set_i = 1'b0;
  logic [AW-1:0] add_i = '0;
  logic          wen_i = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic [3:0]    be_i = '0;
  logic [IW-1:0] id_i = '0;
  logic          gnt_o;
  logic          r_valid_o;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_add_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_be_o;
  logic [DW-1:0] sram_rdata_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          chk;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem  [0:63];

  always #5 clk_i = ~clk_i;

  hci_tcdm_bank_ctrl #(
    .AW (AW), .DW (DW), .BW (8), .UW (0), .IW (IW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .ts_set_i     (ts_set_i),
    .add_i        (add_i),
    .wen_i        (wen_i),
    .data_i       (data_i),
    .be_i         (be_i),
    .id_i         (id_i),
    .gnt_o        (gnt_o),
    .r_valid_o    (r_valid_o),
    .r_data_o     (r_data_o),
    .r_id_o       (r_id_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_add_o   (sram_add_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i)
  );

  // Behavioural single-port SRAM: bit-masked write, registered read data held
  // on cycles without a read.
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o)
        sram_mem[sram_add_o] <= (sram_mem[sram_add_o] & ~sram_be_o) | (sram_wdata_o & sram_be_o);
      else
        sram_rdata_i <= sram_mem[sram_add_o];
    end
  end

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && r_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: r_id=%0h r_data=%08h with nothing outstanding", r_id_o, r_data_o);
        end else begin
          e = exp_q.pop_front();
          if (r_id_o !== e.id) begin
            errors++;
            $display("FAIL resp_id: got %0h expected %0h", r_id_o, e.id);
          end
          if (e.chk) begin
            checks++;
            if (r_data_o !== e.data) begin
              errors++;
              $display("FAIL resp_data id=%0h: got %08h expected %08h", e.id, r_data_o, e.data);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  // Present a request, hold it until granted (bounded), queue its expectation.
  task automatic issue(input logic ts, input logic [AW-1:0] a, input logic wen,
                       input logic [DW-1:0] d, input logic [3:0] be,
                       input logic [IW-1:0] id, input logic chk,
                       input logic [DW-1:0] exp_data, output int waits);
    exp_t e;
    logic granted;
    req_i = 1'b1; ts_set_i = ts; add_i = a; wen_i = wen;
    data_i = d; be_i = be; id_i = id;
    waits = 0;
    granted = 1'b0;
    while (!granted && waits < 8) begin
      @(negedge clk_i);
      if (gnt_o) granted = 1'b1;
      @(posedge clk_i);
      if (granted) begin
        e.chk = chk; e.id = id; e.data = exp_data;
        exp_q.push_back(e);
      end else begin
        waits++;
      end
    end
    if (!granted) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: addr %0d never granted after %0d cycles", a, waits);
    end
    #1;
    req_i = 1'b0; ts_set_i = 1'b0; wen_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [AW-1:0] a;
    logic          wen;
    logic [DW-1:0] d;
    logic [3:0]    be;
    logic [IW-1:0] id;

    // Reset and idle state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("reset_r_valid", {31'd0, r_valid_o}, 32'd0);
    check("reset_r_id", {12'd0, r_id_o}, 32'd0);
    check("reset_gnt", {31'd0, gnt_o}, 32'd1);
    check("reset_r_data", r_data_o, 32'd0);

    // Write then read back at the next cycle.
    issue(1'b0, 10'd5, 1'b0, 32'hDEADBEEF, 4'hF, 20'd3, 1'b0, '0, w);
    issue(1'b0, 10'd5, 1'b1, 32'h0, 4'hF, 20'd7, 1'b1, 32'hDEADBEEF, w);

    // Partial byte write into an existing word.
    issue(1'b0, 10'd20, 1'b0, 32'h11223344, 4'hF, 20'd4, 1'b0, '0, w);
    issue(1'b0, 10'd20, 1'b0, 32'h0000AB00, 4'b0010, 20'd5, 1'b0, '0, w);
    issue(1'b0, 10'd20, 1'b1, 32'h0, 4'hF, 20'd6, 1'b1, 32'h1122AB44, w);
    // A write response shows the last read value.
    issue(1'b0, 10'd21, 1'b0, 32'h55555555, 4'hF, 20'd8, 1'b1, 32'h1122AB44, w);

    // Test-and-set on a zero word, then a read held on req_i.
    issue(1'b0, 10'd9, 1'b0, 32'h0, 4'hF, 20'd1, 1'b0, '0, w);
    issue(1'b1, 10'd9, 1'b1, 32'h0, 4'hF, 20'd2, 1'b1, 32'h0, w);
    check("ts_grant_waits", w, 32'd0);
    issue(1'b0, 10'd9, 1'b1, 32'h0, 4'hF, 20'd10, 1'b1, 32'hFFFFFFFF, w);
    check("read_after_ts_waits", w, 32'd1);

    // ts_set_i on a write is an ordinary write.
    issue(1'b1, 10'd22, 1'b0, 32'hCAFEF00D, 4'hF, 20'd13, 1'b0, '0, w);
    issue(1'b0, 10'd22, 1'b1, 32'h0, 4'hF, 20'd14, 1'b1, 32'hCAFEF00D, w);
    check("ts_write_waits", w, 32'd0);

    // Random back-to-back traffic on a separate region against a model.
    for (int i = 32; i < 64; i++) begin
      ref_mem[i] = 32'h0;
      issue(1'b0, AW'(i), 1'b0, 32'h0, 4'hF, IW'(i), 1'b0, '0, w);
    end
    for (int n = 0; n < 100; n++) begin
      a   = AW'(32 + $urandom_range(0, 31));
      wen = 1'($urandom_range(0, 1));
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      id  = IW'($urandom_range(0, (1 << IW) - 1));
      if (wen) begin
        issue(1'b0, a, 1'b1, d, be, id, 1'b1, ref_mem[a], w);
      end else begin
        issue(1'b0, a, 1'b0, d, be, id, 1'b0, '0, w);
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end

    // Reset while the test-and-set write is pending leaves the word alone.
    issue(1'b0, 10'd12, 1'b0, 32'h12345678, 4'hF, 20'd11, 1'b0, '0, w);
    req_i = 1'b1; ts_set_i = 1'b1; wen_i = 1'b1; add_i = 10'd12; id_i = 20'd12;
    @(negedge clk_i);
    check("ts_abort_grant", {31'd0, gnt_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; ts_set_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("ts_abort_gnt_in_reset", {31'd0, gnt_o}, 32'd1);
    check("ts_abort_rvalid", {31'd0, r_valid_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    issue(1'b0, 10'd12, 1'b1, 32'h0, 4'hF, 20'd15, 1'b1, 32'h12345678, w);
    check("post_abort_waits", w, 32'd0);

    repeat (3) @(posedge clk_i);
    check("outstanding_left", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
